signed_divider: RTL and testbench

SIGNED_DIVIDER -- requirements
Module: signed_divider

---
 rtl/signed_divider.sv | 135 +++++++++++++
 tb/tb_signed_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one bit per cycle,
// followed by a sign fix-up step. Quotient truncates toward zero; remainder takes the dividend's sign.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring step per cycle, WIDTH cycles
// FIX   | apply signs, handle divide-by-zero, write result registers
// DONE  | pulse done next cycle; start here chains the next division
module signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH:0]   rem_shift_d;
    logic [WIDTH+1:0] diff_d;
    logic [WIDTH-1:0] dvd_mag_d;
    logic [WIDTH-1:0] dvs_mag_d;
    logic [WIDTH-1:0] quo_fix_d;
    logic [WIDTH-1:0] rem_fix_d;

    // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    assign dvd_mag_d   = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign dvs_mag_d   = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

    assign rem_shift_d = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign diff_d      = {1'b0, rem_shift_d} - {2'b00, dvs_q};

    assign quo_fix_d   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix_d   = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE) begin
                        done_q <= 1'b1;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (start) begin
                        rem_q     <= '0;
                        quo_q     <= dvd_mag_d;
                        dvs_q     <= dvs_mag_d;
                        dvd_q     <= dividend;
                        neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_q <= dividend[WIDTH-1];
                        zero_q    <= (divisor == '0);
                        cnt_q     <= CW'(WIDTH - 1);
                        state_q   <= CALC;
                        busy_q    <= 1'b1;
                    end
                end
                CALC: begin
                    // A negative difference means the trial subtraction failed: keep the shifted value.
                    rem_q <= diff_d[WIDTH+1] ? rem_shift_d : diff_d[WIDTH:0];
                    quo_q <= {quo_q[WIDTH-2:0], ~diff_d[WIDTH+1]};
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    if (zero_q) begin
                        quotient_q  <= '1;
                        remainder_q <= dvd_q;
                        dbz_q       <= 1'b1;
                    end else begin
                        quotient_q  <= quo_fix_d;
                        remainder_q <= rem_fix_d;
                        dbz_q       <= 1'b0;
                    end
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_divider.sv
// Directed testbench for signed_divider (WIDTH = 32) with hand-computed expected results.
module tb_signed_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int passed = 0;

    signed_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic go(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns number of rising edges until done is seen, or -1 if it never shows up.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passed++;
        checks++; if (quotient !== 32'h0) $display("FAIL reset_quot got %h want 0", quotient); else passed++;
        checks++; if (remainder !== 32'h0) $display("FAIL reset_rem got %h want 0", remainder); else passed++;
        checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %0b want 0", div_by_zero); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        go(32'd100, 32'd7);
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy got %0b want 1", busy); else passed++;
        wait_done(lat);
        checks++; if (lat != 34) $display("FAIL basic_latency got %0d want 34", lat); else passed++;
        checks++; if (quotient !== 32'd14) $display("FAIL basic_quot got %h want %h", quotient, 32'd14); else passed++;
        checks++; if (remainder !== 32'd2) $display("FAIL basic_rem got %h want %h", remainder, 32'd2); else passed++;
        checks++; if (div_by_zero !== 1'b0) $display("FAIL basic_dbz got %0b want 0", div_by_zero); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %0b want 0", busy); else passed++;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) $display("FAIL basic_done_width got %0b want 0", done); else passed++;
    endtask

    task automatic test_signs;
        int lat;
        go(32'hFFFFFF9C, 32'd7);
        wait_done(lat);
        checks++; if (lat != 34) $display("FAIL neg_pos_latency got %0d want 34", lat); else passed++;
        checks++; if (quotient !== 32'hFFFFFFF2) $display("FAIL neg_pos_quot got %h want fffffff2", quotient); else passed++;
        checks++; if (remainder !== 32'hFFFFFFFE) $display("FAIL neg_pos_rem got %h want fffffffe", remainder); else passed++;
        go(32'd100, 32'hFFFFFFF9);
        wait_done(lat);
        checks++; if (quotient !== 32'hFFFFFFF2) $display("FAIL pos_neg_quot got %h want fffffff2", quotient); else passed++;
        checks++; if (remainder !== 32'd2) $display("FAIL pos_neg_rem got %h want 2", remainder); else passed++;
        go(32'hFFFFFF9C, 32'hFFFFFFF9);
        wait_done(lat);
        checks++; if (quotient !== 32'd14) $display("FAIL neg_neg_quot got %h want e", quotient); else passed++;
        checks++; if (remainder !== 32'hFFFFFFFE) $display("FAIL neg_neg_rem got %h want fffffffe", remainder); else passed++;
    endtask

    task automatic test_overflow;
        int lat;
        go(32'h80000000, 32'hFFFFFFFF);
        wait_done(lat);
        checks++; if (lat != 34) $display("FAIL ovf_latency got %0d want 34", lat); else passed++;
        checks++; if (quotient !== 32'h80000000) $display("FAIL ovf_quot got %h want 80000000", quotient); else passed++;
        checks++; if (remainder !== 32'h0) $display("FAIL ovf_rem got %h want 0", remainder); else passed++;
        checks++; if (div_by_zero !== 1'b0) $display("FAIL ovf_dbz got %0b want 0", div_by_zero); else passed++;
        go(32'h80000000, 32'd1);
        wait_done(lat);
        checks++; if (quotient !== 32'h80000000) $display("FAIL min_by_one_quot got %h want 80000000", quotient); else passed++;
        checks++; if (remainder !== 32'h0) $display("FAIL min_by_one_rem got %h want 0", remainder); else passed++;
    endtask

    task automatic test_div_zero;
        int lat;
        go(32'd5, 32'd0);
        wait_done(lat);
        checks++; if (lat != 34) $display("FAIL dz_latency got %0d want 34", lat); else passed++;
        checks++; if (quotient !== 32'hFFFFFFFF) $display("FAIL dz_quot got %h want ffffffff", quotient); else passed++;
        checks++; if (remainder !== 32'd5) $display("FAIL dz_rem got %h want 5", remainder); else passed++;
        checks++; if (div_by_zero !== 1'b1) $display("FAIL dz_flag got %0b want 1", div_by_zero); else passed++;
        go(32'd9, 32'd3);
        wait_done(lat);
        checks++; if (quotient !== 32'd3) $display("FAIL after_dz_quot got %h want 3", quotient); else passed++;
        checks++; if (remainder !== 32'd0) $display("FAIL after_dz_rem got %h want 0", remainder); else passed++;
        checks++; if (div_by_zero !== 1'b0) $display("FAIL after_dz_flag got %0b want 0", div_by_zero); else passed++;
    endtask

    task automatic test_ignore_start;
        int lat;
        go(32'd1000, 32'd10);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        checks++; if (lat + 5 != 34) $display("FAIL ignore_latency got %0d want 34", lat + 5); else passed++;
        checks++; if (quotient !== 32'd100) $display("FAIL ignore_quot got %h want 64", quotient); else passed++;
        checks++; if (remainder !== 32'd0) $display("FAIL ignore_rem got %h want 0", remainder); else passed++;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (quotient !== 32'd100 || remainder !== 32'd0)
            $display("FAIL hold_result got %h/%h want 64/0", quotient, remainder); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL hold_idle_busy got %0b want 0", busy); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat;
        lat = -1;
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd6;
        @(posedge clk);
        #1;
        dividend = 32'd77;
        divisor  = 32'd5;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        checks++; if (lat != 34) $display("FAIL b2b_first_latency got %0d want 34", lat); else passed++;
        checks++; if (quotient !== 32'd8) $display("FAIL b2b_first_quot got %h want 8", quotient); else passed++;
        checks++; if (remainder !== 32'd2) $display("FAIL b2b_first_rem got %h want 2", remainder); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL b2b_no_gap_busy got %0b want 1", busy); else passed++;
        wait_done(lat);
        checks++; if (lat != 34) $display("FAIL b2b_second_latency got %0d want 34", lat); else passed++;
        checks++; if (quotient !== 32'd15) $display("FAIL b2b_second_quot got %h want f", quotient); else passed++;
        checks++; if (remainder !== 32'd2) $display("FAIL b2b_second_rem got %h want 2", remainder); else passed++;
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        go(32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_ctrl got busy=%0b done=%0b want 0/0", busy, done); else passed++;
        checks++; if (quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0)
            $display("FAIL midrst_outputs got %h/%h/%0b want 0/0/0", quotient, remainder, div_by_zero); else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        checks++; if (seen != 0) $display("FAIL midrst_abandon got %0d active cycles want 0", seen); else passed++;
        go(32'd20, 32'hFFFFFFFD);
        wait_done(lat);
        checks++; if (lat != 34) $display("FAIL midrst_next_latency got %0d want 34", lat); else passed++;
        checks++; if (quotient !== 32'hFFFFFFFA) $display("FAIL midrst_next_quot got %h want fffffffa", quotient); else passed++;
        checks++; if (remainder !== 32'd2) $display("FAIL midrst_next_rem got %h want 2", remainder); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
